// File: rtl/steering_sequencer.sv
// Purpose : frame-synchronous line-follower steering; syncs/debounces inputs, steps the drive FSM once per servo frame, drives two PWM outputs.
// Latency : sensor edge accepted 2+DEBOUNCE_CYC cycles later, applied at the next frame boundary; PWM/frame_tick lag the frame counter by one cycle.
// Backpressure: none; free-running, inputs are sampled every cycle and outputs are never stalled.
//
// Ports:
//   clk            system clock
//   rst            asynchronous, active-low reset
//   sensor[1:0]    raw line sensors, [0]=left, [1]=right, 1 = line seen
//   sw[1:0]        sw[0]=1 forces rest (IDLE), sw[1]=1 selects slow mode
//   servo_steering PWM, [0]=left wheel, [1]=right wheel
//   follower_state current FSM state (IDLE=0 FWD=1 LEFT=2 RIGHT=3 SEARCH=4 HALT=5)
//   frame_tick     one-cycle pulse on the first output cycle of each frame
module steering_sequencer #(
    parameter int PWM_PERIOD_CYC = 2000000,
    parameter int PULSE_STOP     = 150000,
    parameter int PULSE_DELTA    = 50000,
    parameter int DEBOUNCE_CYC   = 100000,
    parameter int LOST_FRAMES    = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] sensor,
    input  logic [1:0] sw,
    output logic [1:0] servo_steering,
    output logic [2:0] follower_state,
    output logic       frame_tick
);

    localparam int CW = (PWM_PERIOD_CYC > 1) ? $clog2(PWM_PERIOD_CYC) : 1;
    localparam int DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int LW = (LOST_FRAMES > 1) ? $clog2(LOST_FRAMES) : 1;

    localparam logic [CW-1:0] FRAME_LAST = CW'(PWM_PERIOD_CYC - 1);
    localparam logic [CW-1:0] W_STOP     = CW'(PULSE_STOP);
    localparam logic [CW-1:0] W_DELTA    = CW'(PULSE_DELTA);
    localparam logic [CW-1:0] W_DELTA_SL = CW'(PULSE_DELTA / 2);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYC - 1);
    localparam logic [LW-1:0] LOST_LAST  = LW'(LOST_FRAMES - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FWD    = 3'd1,
        ST_LEFT   = 3'd2,
        ST_RIGHT  = 3'd3,
        ST_SEARCH = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [1:0]         sensor_meta_q, sensor_meta_d;
    logic [1:0]         sensor_sync_q, sensor_sync_d;
    logic [1:0]         sw_meta_q, sw_meta_d;
    logic [1:0]         sw_sync_q, sw_sync_d;
    logic [1:0][DW-1:0] deb_cnt_q, deb_cnt_d;
    logic [1:0]         sensor_acc_q, sensor_acc_d;
    logic [CW-1:0]      frame_cnt_q, frame_cnt_d;
    state_t             state_q, state_d;
    logic [LW-1:0]      lost_cnt_q, lost_cnt_d;
    logic               last_dir_q, last_dir_d;   // 0 = left, 1 = right
    logic [CW-1:0]      width_l_q, width_l_d;
    logic [CW-1:0]      width_r_q, width_r_d;
    logic [1:0]         servo_q, servo_d;
    logic               frame_tick_q, frame_tick_d;

    // ------------------------------------------------------------------
    // Synchronisers and per-bit debounce
    // ------------------------------------------------------------------
    always_comb begin
        sensor_meta_d = sensor;
        sensor_sync_d = sensor_meta_q;
        sw_meta_d     = sw;
        sw_sync_d     = sw_meta_q;
        deb_cnt_d     = deb_cnt_q;
        sensor_acc_d  = sensor_acc_q;
        for (int i = 0; i < 2; i++) begin
            if (sensor_sync_q[i] != sensor_acc_q[i]) begin
                // DEBOUNCE_CYC consecutive differing samples flip the accepted value
                if (deb_cnt_q[i] == DEB_LAST) begin
                    sensor_acc_d[i] = sensor_sync_q[i];
                    deb_cnt_d[i]    = '0;
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
                end
            end else begin
                deb_cnt_d[i] = '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame counter
    // ------------------------------------------------------------------
    logic frame_end;

    always_comb begin
        frame_end   = (frame_cnt_q == FRAME_LAST);
        frame_cnt_d = frame_end ? '0 : frame_cnt_q + 1'b1;
    end

    // ------------------------------------------------------------------
    // Drive FSM and width selection, evaluated only at the frame boundary
    // so that state and widths change together at count 0.
    // ------------------------------------------------------------------
    state_t        sel_state;
    state_t        nxt_state;
    logic [CW-1:0] delta;
    logic [CW-1:0] half;
    logic          turn_reselect;

    always_comb begin
        // Direction requested by the accepted sensors alone
        case (sensor_acc_q)
            2'b00:   sel_state = ST_FWD;
            2'b01:   sel_state = ST_LEFT;
            2'b10:   sel_state = ST_RIGHT;
            default: sel_state = ST_HALT;
        endcase

        turn_reselect = (sel_state == state_q) &&
                        ((state_q == ST_LEFT) || (state_q == ST_RIGHT));

        nxt_state = state_q;
        if (sw_sync_q[0]) begin
            nxt_state = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: nxt_state = ST_FWD;
                ST_FWD, ST_LEFT, ST_RIGHT: begin
                    // Stuck turning for LOST_FRAMES frames: line probably lost
                    if (turn_reselect && (lost_cnt_q == LOST_LAST)) begin
                        nxt_state = ST_SEARCH;
                    end else begin
                        nxt_state = sel_state;
                    end
                end
                ST_SEARCH: begin
                    if (sensor_acc_q == 2'b00) begin
                        nxt_state = ST_FWD;
                    end else if (sensor_acc_q == 2'b11) begin
                        nxt_state = ST_HALT;
                    end else begin
                        nxt_state = ST_SEARCH;
                    end
                end
                ST_HALT: nxt_state = ST_HALT;
                default: nxt_state = ST_IDLE;
            endcase
        end

        delta = sw_sync_q[1] ? W_DELTA_SL : W_DELTA;
        half  = delta >> 1;

        state_d    = state_q;
        lost_cnt_d = lost_cnt_q;
        last_dir_d = last_dir_q;
        width_l_d  = width_l_q;
        width_r_d  = width_r_q;

        if (frame_end) begin
            state_d = nxt_state;

            if ((nxt_state == state_q) &&
                ((state_q == ST_LEFT) || (state_q == ST_RIGHT))) begin
                lost_cnt_d = lost_cnt_q + 1'b1;
            end else begin
                lost_cnt_d = '0;
            end

            if (nxt_state == ST_LEFT) begin
                last_dir_d = 1'b0;
            end else if (nxt_state == ST_RIGHT) begin
                last_dir_d = 1'b1;
            end

            // Right servo is mirror-mounted: forward is below PULSE_STOP
            case (nxt_state)
                ST_FWD: begin
                    width_l_d = W_STOP + delta;
                    width_r_d = W_STOP - delta;
                end
                ST_LEFT: begin
                    width_l_d = W_STOP;
                    width_r_d = W_STOP - delta;
                end
                ST_RIGHT: begin
                    width_l_d = W_STOP + delta;
                    width_r_d = W_STOP;
                end
                ST_SEARCH: begin
                    // Spin in place toward the side the line was last seen
                    // (entering SEARCH never changes last_dir)
                    if (last_dir_q) begin
                        width_l_d = W_STOP + half;
                        width_r_d = W_STOP + half;
                    end else begin
                        width_l_d = W_STOP - half;
                        width_r_d = W_STOP - half;
                    end
                end
                default: begin
                    width_l_d = W_STOP;
                    width_r_d = W_STOP;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // PWM and frame tick, both registered off the same counter value
    // ------------------------------------------------------------------
    always_comb begin
        servo_d[0]   = (frame_cnt_q < width_l_q);
        servo_d[1]   = (frame_cnt_q < width_r_q);
        frame_tick_d = (frame_cnt_q == '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sensor_meta_q <= '0;
            sensor_sync_q <= '0;
            sw_meta_q     <= '0;
            sw_sync_q     <= '0;
            deb_cnt_q     <= '0;
            sensor_acc_q  <= '0;
            frame_cnt_q   <= '0;
            state_q       <= ST_IDLE;
            lost_cnt_q    <= '0;
            last_dir_q    <= 1'b0;
            width_l_q     <= W_STOP;
            width_r_q     <= W_STOP;
            servo_q       <= '0;
            frame_tick_q  <= 1'b0;
        end else begin
            sensor_meta_q <= sensor_meta_d;
            sensor_sync_q <= sensor_sync_d;
            sw_meta_q     <= sw_meta_d;
            sw_sync_q     <= sw_sync_d;
            deb_cnt_q     <= deb_cnt_d;
            sensor_acc_q  <= sensor_acc_d;
            frame_cnt_q   <= frame_cnt_d;
            state_q       <= state_d;
            lost_cnt_q    <= lost_cnt_d;
            last_dir_q    <= last_dir_d;
            width_l_q     <= width_l_d;
            width_r_q     <= width_r_d;
            servo_q       <= servo_d;
            frame_tick_q  <= frame_tick_d;
        end
    end

    assign servo_steering = servo_q;
    assign follower_state = state_q;
    assign frame_tick     = frame_tick_q;

endmodule
